// File: rtl/coherence_ctrl.sv
// Coherence controller for two snooping data caches that share one RAM port.
// Serialises write-backs and BusRd/BusRdX, moving two-word blocks cache-to-cache or RAM-to-cache.
module coherence_ctrl (
    input  logic             CLK,
    input  logic             nRST,
    input  logic [1:0]       dREN,
    input  logic [1:0]       dWEN,
    input  logic [1:0][31:0] daddr,
    input  logic [1:0][31:0] dstore,
    input  logic [1:0]       cctrans,
    input  logic [1:0]       ccwrite,
    output logic [1:0]       dwait,
    output logic [1:0][31:0] dload,
    output logic [1:0]       ccwait,
    output logic [1:0]       ccinv,
    output logic [1:0][31:0] ccsnoopaddr,
    output logic             ramREN,
    output logic             ramWEN,
    output logic [31:0]      ramaddr,
    output logic [31:0]      ramstore,
    input  logic [31:0]      ramload,
    input  logic [1:0]       ramstate
);

    localparam int unsigned DW         = 32;
    localparam logic [1:0]  RAM_ACCESS = 2'd2;

    typedef enum logic [3:0] {
        IDLE,
        WB,
        SNOOP1,
        SNOOP2,
        XFER1,
        XFER2,
        RAMRD1,
        RAMRD2,
        DONE
    } state_e;

    state_e          state_q, state_d;
    logic            last_q, last_d;
    logic            r_q, r_d;
    logic            inv_q, inv_d;
    logic [DW-1:0]   addr_q, addr_d;

    logic            snp;
    logic            ram_acc;
    logic [1:0]      wb_req;
    logic [1:0]      co_req;
    logic [1:0]      arb_req;
    logic            win;
    logic [DW-1:0]   word_addr;

    // Round-robin arbitration; write-backs shadow coherence requests entirely
    always_comb begin
        wb_req  = dWEN & ~cctrans;
        co_req  = dREN & cctrans;
        arb_req = (wb_req != 2'b00) ? wb_req : co_req;
        win     = (arb_req == 2'b11) ? ~last_q : arb_req[1];
    end

    always_comb begin
        snp       = ~r_q;
        ram_acc   = (ramstate == RAM_ACCESS);
        word_addr = ((state_q == XFER2) || (state_q == RAMRD2)) ? (addr_q | DW'(4)) : addr_q;
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
            r_q     <= 1'b0;
            inv_q   <= 1'b0;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            r_q     <= r_d;
            inv_q   <= inv_d;
            addr_q  <= addr_d;
        end
    end

    // Next state and cycle outputs; a word completes only on a RAM ACCESS cycle
    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        r_d         = r_q;
        inv_d       = inv_q;
        addr_d      = addr_q;
        dwait       = 2'b11;
        dload       = '0;
        ccwait      = 2'b00;
        ccinv       = 2'b00;
        ccsnoopaddr = '0;
        ramREN      = 1'b0;
        ramWEN      = 1'b0;
        ramaddr     = '0;
        ramstore    = '0;

        if ((state_q != IDLE) && (state_q != WB)) begin
            ccwait[snp]      = 1'b1;
            ccsnoopaddr[snp] = addr_q;
        end

        case (state_q)
            IDLE: begin
                if (wb_req != 2'b00) begin
                    r_d     = win;
                    last_d  = win;
                    state_d = WB;
                end else if (co_req != 2'b00) begin
                    r_d     = win;
                    last_d  = win;
                    inv_d   = ccwrite[win];
                    addr_d  = {daddr[win][DW-1:3], 3'b000};
                    state_d = SNOOP1;
                end
            end
            WB: begin
                ramWEN     = 1'b1;
                ramaddr    = daddr[r_q];
                ramstore   = dstore[r_q];
                dwait[r_q] = ~ram_acc;
                if (!dWEN[r_q]) begin
                    state_d = IDLE;
                end
            end
            SNOOP1: begin
                state_d = SNOOP2;
            end
            SNOOP2: begin
                state_d = ccwrite[snp] ? XFER1 : RAMRD1;
            end
            XFER1, XFER2: begin
                ramWEN     = dWEN[snp];
                ramaddr    = word_addr;
                ramstore   = dstore[snp];
                dload[r_q] = dstore[snp];
                if (state_q == XFER2) begin
                    ccinv[snp] = inv_q;
                end
                if (ram_acc && dWEN[snp]) begin
                    dwait   = 2'b00;
                    state_d = (state_q == XFER1) ? XFER2 : DONE;
                end
            end
            RAMRD1, RAMRD2: begin
                ramREN     = 1'b1;
                ramaddr    = word_addr;
                dload[r_q] = ramload;
                if (ram_acc) begin
                    dwait[r_q] = 1'b0;
                    state_d    = (state_q == RAMRD1) ? RAMRD2 : DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: doc/coherence_ctrl.md
COHERENCE_CTRL -- requirements
Module: coherence_ctrl

Interface
REQ-001 Parameters: none; exactly two data caches, indices 0 and 1.
REQ-002 CLK  in  1  clock; all state changes on the rising edge.
REQ-003 nRST  in  1  reset, asynchronous, active-low.
REQ-004 dREN[1:0], dWEN[1:0]  in  2  per-cache read and write requests.
REQ-005 daddr[1:0], dstore[1:0]  in  2x32  per-cache word address and write data.
REQ-006 cctrans[1:0], ccwrite[1:0]  in  2  per-cache coherence transaction request, and the BusRdX flag (requester) or snoop-hit reply (snooper).
REQ-007 dwait[1:0]  out  2  per-cache stall; 0 means the word completed this cycle.
REQ-008 dload[1:0]  out  2x32  per-cache read data.
REQ-009 ccwait[1:0], ccinv[1:0]  out  2  snoop-in-progress and invalidate-after-transfer, per cache.
REQ-010 ccsnoopaddr[1:0]  out  2x32  snooped address, per cache.
REQ-011 ramREN, ramWEN  out  1  RAM read and write strobes; ramaddr, ramstore  out  32  RAM address and data; ramload  in  32  RAM data; ramstate  in  2  FREE/BUSY/ACCESS/ERROR.

Function
REQ-012 States: IDLE, WB, SNOOP1, SNOOP2, XFER1, XFER2, RAMRD1, RAMRD2, DONE.
REQ-013 Arbitration in IDLE uses a round-robin bit `last` (reset 1); when both caches request, the cache != last wins, and `last` updates on grant.
REQ-014 In IDLE, a dWEN with cctrans=0 is a write-back: grant, go to WB, and pass daddr/dstore of the winner to the RAM with ramWEN=1.
REQ-015 In WB, dwait[r] = (ramstate != ACCESS); stay in WB while dWEN[r]=1, then go to IDLE. Each word is one ACCESS.
REQ-016 In IDLE, a dREN with cctrans=1 latches requester r, addr={daddr[31:3],3'b000}, and inv=ccwrite[r], then goes to SNOOP1.
REQ-017 A write-back request takes priority over a coherence request.
REQ-018 In SNOOP1, SNOOP2, XFER1, XFER2 and DONE: ccwait[~r]=1 and ccsnoopaddr[~r]=addr; dwait[r]=1 except as stated in REQ-020 and REQ-021.
REQ-019 SNOOP1 always goes to SNOOP2. SNOOP2 goes to XFER1 if ccwrite[~r]=1, otherwise to RAMRD1.
REQ-020 In XFER1, the snooper's dWEN/dstore drive a RAM write at addr, and dload[r]=dstore[~r]. On ramstate==ACCESS with dWEN[~r]=1: dwait[~r]=0, dwait[r]=0, and go to XFER2.
REQ-021 XFER2 is the same at addr|4 and goes to DONE. During XFER2, ccinv[~r]=inv.
REQ-022 In RAMRD1, ramREN=1 at addr and dload[r]=ramload; on ACCESS, dwait[r]=0 and go to RAMRD2. RAMRD2 is the same at addr|4 and goes to DONE.
REQ-023 DONE deasserts nothing early, lasts one cycle, and returns to IDLE; ccwait drops on entry to IDLE.
REQ-024 ramstate ERROR or BUSY: hold the current state with all dwait=1; no retry limit.
REQ-025 A requester that drops dREN mid-transaction does not abort it; the transaction completes to RAM, with the requester's data discarded.
REQ-026 Idle defaults: dwait=2'b11, dload=0, ccwait=0, ccinv=0, ccsnoopaddr=0, and all RAM strobes and buses 0.

Reset
REQ-027 Asynchronous assertion of nRST=0 forces IDLE, last=1, r=0, inv=0, addr=0, and all outputs to the REQ-026 values within the same cycle, including mid-transaction.
REQ-028 The first arbitration after reset grants cache 0 when both caches request.

Verification
REQ-029 Both caches issue cctrans+dREN together after reset -> cache 0 granted; ccwait[1]=1 for cycles 1-2; then cache 1 is granted next time.
REQ-030 Cache 0 BusRd of 0x100 with no snoop hit and RAM ACCESS every cycle -> ramaddr 0x100 then 0x104; dwait[0] low once for each, with dload = ramload.
REQ-031 Cache 1 BusRdX of 0x200 with cache 0 snoop hit, dstore 0xAAAA then 0xBBBB -> dload[1] = 0xAAAA then 0xBBBB; RAM written at 0x200/0x204; ccinv[0]=1 in XFER2.
REQ-032 Write-back from cache 1 concurrent with a BusRd from cache 0 -> write-back served first; the BusRd starts after WB returns to IDLE.
REQ-033 nRST pulsed during RAMRD2 -> all outputs reach idle values immediately; a fresh request completes normally afterwards.
REQ-034 ramstate=BUSY for 3 cycles in XFER1 -> state held and both dwait stay 1 until ACCESS.
